// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the trap/redirect sequencer: cause codes, state
// encodings and the mtvec alignment helper.
package trap_ctrl_pkg;

  localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
  localparam logic [31:0] CAUSE_EBREAK  = 32'd3;
  localparam logic [31:0] CAUSE_ECALL_M = 32'd11;
  localparam logic [31:0] CAUSE_IRQ_EXT = 32'h8000_000B;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_SAVE = 2'd1,
    ST_VEC  = 2'd2,
    ST_RET  = 2'd3
  } trap_state_e;

  // Clears the low 'bits' bits of an address (direct-mode vector base).
  function automatic logic [31:0] align_down(input logic [31:0] addr,
                                             input int unsigned bits);
    logic [31:0] mask;
    mask = ~((32'd1 << bits) - 32'd1);
    return addr & mask;
  endfunction

endpackage

// File: rtl/trap_ctrl.sv
// Pipeline sequencer for synchronous traps, external interrupts, mret and
// taken jumps; drives flush/kill, CSR writes and a single PC redirect.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter logic [31:0] BUBBLE_PC   = 32'hffff_ffff,
  parameter int unsigned MTVEC_ALIGN = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ex__pc,
  input  logic        ex__ins_illegal,
  input  logic        ex__ecall,
  input  logic        ex__ebreak,
  input  logic        ex__trap_return,
  input  logic        ex__jump_taken,
  input  logic [31:0] ex__jump_target,
  input  logic        irq,
  input  logic        csr_mie,
  input  logic [31:0] csr_mtvec,
  input  logic [31:0] csr_mepc,
  output logic        pipe_flush,
  output logic        ex_kill,
  output logic        pc_redirect,
  output logic [31:0] pc_target,
  output logic        mepc_wen,
  output logic [31:0] mepc_wdata,
  output logic        mcause_wen,
  output logic [31:0] mcause_wdata,
  output logic        trap_enter,
  output logic        trap_exit,
  output logic        busy,
  output trap_state_e state_dbg
);

  trap_state_e state_q, state_d;
  logic [31:0] saved_pc_q, saved_pc_d;
  logic [31:0] saved_cause_q, saved_cause_d;

  logic ev_valid;
  logic take_trap;
  logic [31:0] trap_cause;

  assign ev_valid  = (ex__pc != BUBBLE_PC);
  assign state_dbg = state_q;

  // Trap selection in priority order; irq only counts when nothing synchronous is pending.
  always_comb begin
    take_trap  = 1'b0;
    trap_cause = 32'd0;
    if (ev_valid) begin
      if (ex__ins_illegal) begin
        take_trap  = 1'b1;
        trap_cause = CAUSE_ILLEGAL;
      end else if (ex__ebreak) begin
        take_trap  = 1'b1;
        trap_cause = CAUSE_EBREAK;
      end else if (ex__ecall) begin
        take_trap  = 1'b1;
        trap_cause = CAUSE_ECALL_M;
      end else if (!ex__trap_return && !ex__jump_taken && irq && csr_mie) begin
        take_trap  = 1'b1;
        trap_cause = CAUSE_IRQ_EXT;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    saved_pc_d    = saved_pc_q;
    saved_cause_d = saved_cause_q;
    pipe_flush    = 1'b0;
    ex_kill       = 1'b0;
    pc_redirect   = 1'b0;
    pc_target     = 32'd0;
    mepc_wen      = 1'b0;
    mepc_wdata    = 32'd0;
    mcause_wen    = 1'b0;
    mcause_wdata  = 32'd0;
    trap_enter    = 1'b0;
    trap_exit     = 1'b0;
    busy          = 1'b0;

    // While reset is held every output stays low, whatever EX presents.
    if (rst_n) begin
      busy = (state_q != ST_RUN);
      unique case (state_q)
        ST_RUN: begin
          if (take_trap) begin
            pipe_flush    = 1'b1;
            ex_kill       = 1'b1;
            saved_pc_d    = ex__pc;
            saved_cause_d = trap_cause;
            state_d       = ST_SAVE;
          end else if (ev_valid && ex__trap_return) begin
            pipe_flush = 1'b1;
            state_d    = ST_RET;
          end else if (ev_valid && ex__jump_taken) begin
            pipe_flush  = 1'b1;
            pc_redirect = 1'b1;
            pc_target   = ex__jump_target;
          end
        end
        ST_SAVE: begin
          mepc_wen     = 1'b1;
          mepc_wdata   = saved_pc_q;
          mcause_wen   = 1'b1;
          mcause_wdata = saved_cause_q;
          trap_enter   = 1'b1;
          pipe_flush   = 1'b1;
          state_d      = ST_VEC;
        end
        ST_VEC: begin
          pc_redirect = 1'b1;
          pc_target   = align_down(csr_mtvec, MTVEC_ALIGN);
          pipe_flush  = 1'b1;
          state_d     = ST_RUN;
        end
        ST_RET: begin
          // csr_mepc is read here, not at the mret, so a just-retired csrw mepc is seen.
          trap_exit   = 1'b1;
          pc_redirect = 1'b1;
          pc_target   = csr_mepc;
          pipe_flush  = 1'b1;
          state_d     = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      saved_pc_q    <= 32'd0;
      saved_cause_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      saved_pc_q    <= saved_pc_d;
      saved_cause_q <= saved_cause_d;
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: trap entry, mret, irq gating, jumps,
// alignment of mtvec and reset abort in mid-sequence.
module tb_trap_ctrl;
  import trap_ctrl_pkg::*;

  localparam logic [31:0] BUB = 32'hffff_ffff;

  logic        clk;
  logic        rst_n;
  logic [31:0] ex__pc;
  logic        ex__ins_illegal, ex__ecall, ex__ebreak, ex__trap_return, ex__jump_taken;
  logic [31:0] ex__jump_target;
  logic        irq, csr_mie;
  logic [31:0] csr_mtvec, csr_mepc;
  logic        pipe_flush, ex_kill, pc_redirect;
  logic [31:0] pc_target;
  logic        mepc_wen, mcause_wen, trap_enter, trap_exit, busy;
  logic [31:0] mepc_wdata, mcause_wdata;
  trap_state_e state_dbg;

  int checks = 0;
  int errors = 0;

  trap_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .ex__pc(ex__pc), .ex__ins_illegal(ex__ins_illegal), .ex__ecall(ex__ecall),
    .ex__ebreak(ex__ebreak), .ex__trap_return(ex__trap_return),
    .ex__jump_taken(ex__jump_taken), .ex__jump_target(ex__jump_target),
    .irq(irq), .csr_mie(csr_mie), .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
    .pipe_flush(pipe_flush), .ex_kill(ex_kill), .pc_redirect(pc_redirect),
    .pc_target(pc_target), .mepc_wen(mepc_wen), .mepc_wdata(mepc_wdata),
    .mcause_wen(mcause_wen), .mcause_wdata(mcause_wdata),
    .trap_enter(trap_enter), .trap_exit(trap_exit), .busy(busy),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge; inputs are then changed at #1 and outputs sampled at #2.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    ex__pc          = BUB;
    ex__ins_illegal = 1'b0;
    ex__ecall       = 1'b0;
    ex__ebreak      = 1'b0;
    ex__trap_return = 1'b0;
    ex__jump_taken  = 1'b0;
    ex__jump_target = 32'd0;
  endtask

  // Checks the SAVE and VEC cycles that follow a trap accepted in the current cycle.
  task automatic expect_entry(input string tag, input logic [31:0] pc,
                              input logic [31:0] cause, input logic [31:0] vec);
    step(); idle(); settle();
    check({tag, " c1 mepc_wen"},   32'(mepc_wen), 32'd1);
    check({tag, " c1 mepc"},       mepc_wdata, pc);
    check({tag, " c1 mcause_wen"}, 32'(mcause_wen), 32'd1);
    check({tag, " c1 mcause"},     mcause_wdata, cause);
    check({tag, " c1 trap_enter"}, 32'(trap_enter), 32'd1);
    check({tag, " c1 redirect"},   32'(pc_redirect), 32'd0);
    check({tag, " c1 busy"},       32'(busy), 32'd1);
    step(); settle();
    check({tag, " c2 redirect"},   32'(pc_redirect), 32'd1);
    check({tag, " c2 target"},     pc_target, vec);
    check({tag, " c2 flush"},      32'(pipe_flush), 32'd1);
    check({tag, " c2 mepc_wen"},   32'(mepc_wen), 32'd0);
    step(); settle();
    check({tag, " c3 busy"},       32'(busy), 32'd0);
    check({tag, " c3 flush"},      32'(pipe_flush), 32'd0);
  endtask

  initial begin
    // Reset held with active inputs: everything must be 0.
    rst_n = 1'b0;
    idle();
    ex__pc = 32'h100; ex__ins_illegal = 1'b1; ex__jump_taken = 1'b1;
    ex__jump_target = 32'h300; irq = 1'b1; csr_mie = 1'b1;
    csr_mtvec = 32'h200; csr_mepc = 32'h0;
    #2;
    check("rst flush",    32'(pipe_flush), 32'd0);
    check("rst kill",     32'(ex_kill), 32'd0);
    check("rst redirect", 32'(pc_redirect), 32'd0);
    check("rst target",   pc_target, 32'd0);
    check("rst busy",     32'(busy), 32'd0);
    check("rst state",    32'(state_dbg), 32'(ST_RUN));
    step(); step();
    rst_n = 1'b1; idle(); irq = 1'b0; csr_mie = 1'b0;
    step();

    // Illegal at 0x100, mtvec 0x200.
    ex__pc = 32'h100; ex__ins_illegal = 1'b1; settle();
    check("ill c0 flush",    32'(pipe_flush), 32'd1);
    check("ill c0 kill",     32'(ex_kill), 32'd1);
    check("ill c0 redirect", 32'(pc_redirect), 32'd0);
    check("ill c0 busy",     32'(busy), 32'd0);
    expect_entry("ill", 32'h100, 32'd2, 32'h200);

    // ecall and jump together at 0x40: trap wins.
    ex__pc = 32'h40; ex__ecall = 1'b1; ex__jump_taken = 1'b1; ex__jump_target = 32'h300;
    settle();
    check("ecj c0 kill",     32'(ex_kill), 32'd1);
    check("ecj c0 redirect", 32'(pc_redirect), 32'd0);
    expect_entry("ecj", 32'h40, 32'd11, 32'h200);

    // ebreak outranks ecall; mtvec with low bits set is aligned down.
    csr_mtvec = 32'h20F;
    ex__pc = 32'h44; ex__ebreak = 1'b1; ex__ecall = 1'b1; settle();
    check("ebk c0 kill", 32'(ex_kill), 32'd1);
    expect_entry("ebk", 32'h44, 32'd3, 32'h20C);
    csr_mtvec = 32'h200;

    // mret: csr_mepc changes to 0x104 after the mret cycle and must be honoured.
    csr_mepc = 32'h0;
    ex__pc = 32'h180; ex__trap_return = 1'b1; settle();
    check("ret c0 flush",    32'(pipe_flush), 32'd1);
    check("ret c0 kill",     32'(ex_kill), 32'd0);
    check("ret c0 redirect", 32'(pc_redirect), 32'd0);
    step(); idle(); csr_mepc = 32'h104; settle();
    check("ret c1 exit",     32'(trap_exit), 32'd1);
    check("ret c1 redirect", 32'(pc_redirect), 32'd1);
    check("ret c1 target",   pc_target, 32'h104);
    check("ret c1 busy",     32'(busy), 32'd1);
    check("ret c1 mepc_wen", 32'(mepc_wen), 32'd0);
    step(); settle();
    check("ret c2 busy",     32'(busy), 32'd0);
    check("ret c2 exit",     32'(trap_exit), 32'd0);

    // irq with a bubble in EX: no effect; then a real instruction takes it.
    irq = 1'b1; csr_mie = 1'b1; settle();
    check("irqb flush", 32'(pipe_flush), 32'd0);
    check("irqb kill",  32'(ex_kill), 32'd0);
    step(); ex__pc = 32'h80; settle();
    check("irqb busy",  32'(busy), 32'd0);
    check("irq c0 kill", 32'(ex_kill), 32'd1);
    step(); idle(); settle();
    check("irq c1 mepc",   mepc_wdata, 32'h80);
    check("irq c1 mcause", mcause_wdata, 32'h8000_000B);
    check("irq c1 kill",   32'(ex_kill), 32'd0);
    irq = 1'b0;
    step(); settle();
    check("irq c2 target", pc_target, 32'h200);
    step();

    // irq masked: no trap; a jump redirects in the same cycle and stays in RUN.
    irq = 1'b1; csr_mie = 1'b0;
    ex__pc = 32'h90; settle();
    check("mask kill",  32'(ex_kill), 32'd0);
    check("mask flush", 32'(pipe_flush), 32'd0);
    step();
    ex__pc = 32'h94; ex__jump_taken = 1'b1; ex__jump_target = 32'h300; settle();
    check("jmp flush",    32'(pipe_flush), 32'd1);
    check("jmp redirect", 32'(pc_redirect), 32'd1);
    check("jmp target",   pc_target, 32'h300);
    check("jmp kill",     32'(ex_kill), 32'd0);
    step(); idle(); irq = 1'b0; settle();
    check("jmp busy",  32'(busy), 32'd0);
    check("jmp state", 32'(state_dbg), 32'(ST_RUN));

    // Reset pulsed during SAVE aborts the sequence.
    ex__pc = 32'h50; ex__ecall = 1'b1; settle();
    check("rsv c0 kill", 32'(ex_kill), 32'd1);
    step(); idle(); settle();
    check("rsv c1 busy", 32'(busy), 32'd1);
    rst_n = 1'b0; settle();
    check("rsv mepc_wen",   32'(mepc_wen), 32'd0);
    check("rsv mcause_wen", 32'(mcause_wen), 32'd0);
    check("rsv trap_enter", 32'(trap_enter), 32'd0);
    check("rsv busy",       32'(busy), 32'd0);
    step(); rst_n = 1'b1; settle();
    check("rsv post state",    32'(state_dbg), 32'(ST_RUN));
    check("rsv post redirect", 32'(pc_redirect), 32'd0);
    step();
    ex__pc = 32'h60; ex__ecall = 1'b1; settle();
    check("rsv ecall kill", 32'(ex_kill), 32'd1);
    expect_entry("rsv ecall", 32'h60, 32'd11, 32'h200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
